tone_sequencer: RTL and testbench

Queues {note, duration} pairs written by the MCU output port and plays them in order. It drives the 8-bit note code consumed by speak_drive (din), holding each note for its programmed number of ticks. A short silent gap separates consecutive notes. It frees firmware from timing individual notes and is the only writer of speak_drive.din.

---
 rtl/speak_pkg.sv | 17 +
 rtl/note_fifo.sv | 70 +++++++
 rtl/tone_sequencer.sv | 118 +++++++++++
 tb/tb_tone_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/speak_pkg.sv
// Shared types for the tone sequencer: rest code, FSM states, queued note entry.
// No logic; imported by the sequencer and its note FIFO.
// Entry layout is {note, dur}, note in the upper byte.
package speak_pkg;
    localparam logic [7:0] NOTE_REST = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic [7:0] note;
        logic [7:0] dur;
    } entry_t;
endpackage

// File: rtl/note_fifo.sv
// Note FIFO: DEPTH x 16-bit synchronous queue with first-word-fall-through head.
// Latency: a write is visible on head and empty one edge later.
// Backpressure: writes while full are dropped unless a pop happens the same cycle.
module note_fifo
    import speak_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   wr_vld,
    input  entry_t wr_dat,
    input  logic   rd,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          wr_acc;
    logic          rd_acc;

    assign rd_acc = rd && !empty;
    assign wr_acc = wr_vld && (!full || rd_acc);
    assign head   = mem[rp];

    always_comb begin
        cnt_nxt = cnt;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = cnt + (AW + 1)'(1);
        end else if (!wr_acc && rd_acc) begin
            cnt_nxt = cnt - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wp] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_acc) wp <= wp + AW'(1);
            if (rd_acc) rp <= rp + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == DEPTH_C);
            empty <= (cnt_nxt == '0);
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays queued {note, dur} entries on note_out, with a silent gap after each.
// Latency: a write into an empty idle block drives note_out one edge later.
// Backpressure: none to the writer beyond full; overflowing writes are dropped, stop flushes.
module tone_sequencer
    import speak_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_TICKS  = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wr_en,
    input  logic [7:0] wr_note,
    input  logic [7:0] wr_dur,
    input  logic       stop,
    output logic [7:0] note_out,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       done
);
    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(PRESCALE - 1);
    // Gap length is held in the 8-bit duration counter, so it is limited to 255 ticks.
    localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS);

    state_t        state;
    logic [CW-1:0] cyc_cnt;
    logic [7:0]    dur_cnt;
    entry_t        wr_ent;
    entry_t        head;
    logic          tick;
    logic          last_tick;
    logic          pop;
    logic          start;
    logic          finish;

    assign wr_ent    = '{note: wr_note, dur: wr_dur};
    assign tick      = (cyc_cnt == TICK_LAST);
    assign last_tick = tick && (dur_cnt == 8'd1);

    always_comb begin
        pop    = 1'b0;
        finish = 1'b0;
        if (!stop) begin
            if (state == IDLE) begin
                pop = !empty;
            end else if (state == GAP || (state == PLAY && GAP_TICKS == 0)) begin
                pop    = last_tick && !empty;
                finish = last_tick && empty;
            end
        end
        start = pop && (head.dur != 8'd0);
    end

    note_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .flush  (stop),
        .wr_vld (wr_en),
        .wr_dat (wr_ent),
        .rd     (pop),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            dur_cnt  <= '0;
            note_out <= NOTE_REST;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                cyc_cnt  <= '0;
                dur_cnt  <= '0;
                note_out <= NOTE_REST;
                busy     <= 1'b0;
            end else if (start) begin
                state    <= PLAY;
                cyc_cnt  <= '0;
                dur_cnt  <= head.dur;
                note_out <= head.note;
                busy     <= 1'b1;
            end else if (pop) begin
                // Zero-duration entry: discard it and let IDLE look at the next one.
                state    <= IDLE;
                cyc_cnt  <= '0;
                note_out <= NOTE_REST;
                busy     <= 1'b0;
            end else if (state == PLAY && last_tick && GAP_TICKS > 0) begin
                state    <= GAP;
                cyc_cnt  <= '0;
                dur_cnt  <= GAP_LOAD;
                note_out <= NOTE_REST;
            end else if (finish) begin
                state    <= IDLE;
                cyc_cnt  <= '0;
                note_out <= NOTE_REST;
                busy     <= 1'b0;
                done     <= 1'b1;
            end else if (state != IDLE) begin
                cyc_cnt <= tick ? '0 : cyc_cnt + CW'(1);
                if (tick) dur_cnt <= dur_cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with PRESCALE=10 and one gap tick; expectations are queued per cycle
// and a negedge monitor pops and compares them against the outputs.
module tb_tone_sequencer;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_note = 8'h00;
    logic [7:0] wr_dur = 8'h00;
    logic       stop = 1'b0;
    logic [7:0] note_out;
    logic       busy;
    logic       full;
    logic       empty;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [3:0] m;
        logic [7:0] note;
        logic       busy;
        logic       done;
        logic       full;
        logic       empty;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    tone_sequencer #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .FIFO_DEPTH (8),
        .GAP_TICKS  (1)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_en    (wr_en),
        .wr_note  (wr_note),
        .wr_dur   (wr_dur),
        .stop     (stop),
        .note_out (note_out),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .done     (done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input logic [3:0] m, input logic [7:0] n, input logic b,
                        input logic d, input logic f, input logic em);
        exp_t x;
        x.c = c; x.m = m; x.note = n; x.busy = b; x.done = d; x.full = f; x.empty = em;
        sbq.push_back(x);
    endtask

    task automatic ex_out(input int c, input logic [7:0] n, input logic b, input logic d);
        push(c, 4'b0111, n, b, d, 1'b0, 1'b0);
    endtask

    task automatic ex_all(input int c, input logic [7:0] n, input logic b, input logic d,
                          input logic f, input logic em);
        push(c, 4'b1111, n, b, d, f, em);
    endtask

    task automatic ex_run(input int c0, input int len, input logic [7:0] n, input logic b);
        for (int i = 0; i < len; i++) ex_out(c0 + i, n, b, 1'b0);
    endtask

    task automatic ex_done(input int c);
        ex_out(c, 8'h00, 1'b0, 1'b1);
        ex_out(c + 1, 8'h00, 1'b0, 1'b0);
    endtask

    // Called just after a negedge; the write lands on the next rising edge.
    task automatic do_write(input logic [7:0] n, input logic [7:0] d);
        wr_en = 1'b1; wr_note = n; wr_dur = d;
        @(posedge CLK);
        #1 wr_en = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        while (sbq.size() > 0 && sbq[0].c <= cyc) begin
            e = sbq.pop_front();
            if (e.c != cyc) begin
                chk("sb_stale", 16'(e.c), 16'(cyc));
            end else begin
                if (e.m[0]) chk("note_out", 16'(note_out), 16'(e.note));
                if (e.m[1]) chk("busy", 16'(busy), 16'(e.busy));
                if (e.m[2]) chk("done", 16'(done), 16'(e.done));
                if (e.m[3]) begin
                    chk("full", 16'(full), 16'(e.full));
                    chk("empty", 16'(empty), 16'(e.empty));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        // reset state
        ex_all(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        ex_all(2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cyc(2);
        RST_N = 1'b1;
        @(negedge CLK);

        // 1: single note {2A,3}
        n = cyc + 1;
        ex_all(n, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_all(n + 1, 8'h2A, 1'b1, 1'b0, 1'b0, 1'b1);
        ex_run(n + 2, 29, 8'h2A, 1'b1);
        ex_run(n + 31, 10, 8'h00, 1'b1);
        ex_done(n + 41);
        do_write(8'h2A, 8'd3);
        wait_cyc(n + 44);

        // 2: back-to-back with a rest in the middle
        n = cyc + 1;
        ex_run(n + 1, 10, 8'h10, 1'b1);
        ex_run(n + 11, 40, 8'h00, 1'b1);
        ex_run(n + 51, 10, 8'h20, 1'b1);
        ex_run(n + 61, 10, 8'h00, 1'b1);
        ex_done(n + 71);
        do_write(8'h10, 8'd1);
        do_write(8'h00, 8'd2);
        do_write(8'h20, 8'd1);
        wait_cyc(n + 74);

        // 3: fill while a long note plays, overflow drop, write+pop while full
        n = cyc + 1;
        ex_all(n + 8, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        ex_all(n + 9, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        ex_all(n + 31, 8'h61, 1'b1, 1'b0, 1'b1, 1'b0);
        ex_all(n + 51, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_out(n + 171, 8'h68, 1'b1, 1'b0);
        ex_all(n + 191, 8'h6A, 1'b1, 1'b0, 1'b0, 1'b1);
        ex_run(n + 201, 10, 8'h00, 1'b1);
        ex_done(n + 211);
        do_write(8'h55, 8'd2);
        for (int k = 1; k <= 9; k++) do_write(8'h60 + 8'(k), 8'd1);
        wait_cyc(n + 30);
        do_write(8'h6A, 8'd1);
        wait_cyc(n + 214);

        // 4: zero-duration entry is skipped
        n = cyc + 1;
        ex_all(n + 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_run(n + 2, 20, 8'h44, 1'b1);
        ex_run(n + 22, 10, 8'h00, 1'b1);
        ex_done(n + 32);
        do_write(8'h33, 8'd0);
        do_write(8'h44, 8'd2);
        wait_cyc(n + 35);

        // 5: stop mid-note with four entries queued and a coincident write
        n = cyc + 1;
        ex_run(n + 1, 5, 8'h71, 1'b1);
        ex_all(n + 6, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        ex_run(n + 7, 20, 8'h00, 1'b0);
        do_write(8'h71, 8'd3);
        for (int k = 2; k <= 5; k++) do_write(8'h70 + 8'(k), 8'd1);
        wait_cyc(n + 5);
        stop = 1'b1; wr_en = 1'b1; wr_note = 8'h77; wr_dur = 8'd1;
        @(posedge CLK);
        #1 stop = 1'b0; wr_en = 1'b0;
        @(negedge CLK);
        wait_cyc(n + 28);
        m = cyc + 1;
        ex_run(m + 1, 10, 8'h76, 1'b1);
        ex_run(m + 11, 10, 8'h00, 1'b1);
        ex_done(m + 21);
        do_write(8'h76, 8'd1);
        wait_cyc(m + 24);

        // 6: async reset mid-gap with an entry still queued
        n = cyc + 1;
        ex_run(n + 1, 10, 8'h81, 1'b1);
        ex_run(n + 11, 4, 8'h00, 1'b1);
        ex_all(n + 15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        ex_run(n + 16, 3, 8'h00, 1'b0);
        do_write(8'h81, 8'd1);
        do_write(8'h82, 8'd1);
        wait_cyc(n + 14);
        #1 RST_N = 1'b0;
        #2;
        chk("rst_note", 16'(note_out), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_empty", 16'(empty), 16'h0001);
        chk("rst_full", 16'(full), 16'h0000);
        chk("rst_done", 16'(done), 16'h0000);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_cyc(n + 18);
        m = cyc + 1;
        ex_run(m + 1, 20, 8'h83, 1'b1);
        ex_run(m + 21, 10, 8'h00, 1'b1);
        ex_done(m + 31);
        do_write(8'h83, 8'd2);
        wait_cyc(m + 35);

        chk("sb_left", 16'(sbq.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
